// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program-counter / branch-resolution stage for the 8-bit core.
//   Latches the ALU zero flag, resolves Jump/Branch against a writable target LUT,
//   drives Prog_ctr for fetch, and owns the Start/Done run handshake plus the
//   per-run cycle counter.
// Optional feature: define PC_BRANCH_REL_EN to make branches PC-relative
//   (target = Prog_ctr + LUT entry); jumps stay absolute either way.
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   Start                run request (IDLE/HALT -> RUN)
//   Halt_req             halt at current PC (RUN -> HALT)
//   Jump_en, Branch_en   control transfer to LUT[Target_idx]
//   Target_idx           LUT index for jump/branch
//   Flag_we, Zero        capture ALU zero into Zero_q (RUN only)
//   Lut_we/waddr/wdata   LUT write port
//   Prog_ctr             registered PC
//   Zero_q               registered zero flag
//   Busy, Done           decoded from state (RUN / HALT)
//   Cycle_cnt            saturating count of RUN cycles in this run
module pc_branch_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned LUT_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt_req,
    input  logic             Jump_en,
    input  logic             Branch_en,
    input  logic [LUT_W-1:0] Target_idx,
    input  logic             Flag_we,
    input  logic             Zero,
    input  logic             Lut_we,
    input  logic [LUT_W-1:0] Lut_waddr,
    input  logic [PC_W-1:0]  Lut_wdata,
    output logic [PC_W-1:0]  Prog_ctr,
    output logic             Zero_q,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Cycle_cnt
);

    localparam int unsigned LUT_N = 1 << LUT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             zero_nxt;
    logic [PC_W-1:0]  lut_rd;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  lut [LUT_N];

    // Target LUT: no reset, read is asynchronous so a same-cycle write is seen next cycle.
    always_ff @(posedge Clk) begin
        if (Lut_we) begin
            lut[Lut_waddr] <= Lut_wdata;
        end
    end

    assign lut_rd = lut[Target_idx];

`ifdef PC_BRANCH_REL_EN
    // Entry is a two's-complement offset; addition wraps modulo 2**PC_W.
    assign br_target = Prog_ctr + lut_rd;
`else
    assign br_target = lut_rd;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start)    state_nxt = S_RUN;
            S_RUN:   if (Halt_req) state_nxt = S_HALT;
            S_HALT:  if (Start)    state_nxt = S_RUN;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            S_RUN:   Busy = 1'b1;
            S_HALT:  Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values; branch decision uses the pre-edge Zero_q.
    always_comb begin
        pc_nxt   = Prog_ctr;
        cnt_nxt  = Cycle_cnt;
        zero_nxt = Zero_q;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    pc_nxt  = '0;
                    cnt_nxt = '0;
                end
            end
            S_RUN: begin
                if (Cycle_cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = Cycle_cnt + CNT_W'(1);
                end
                if (Flag_we) begin
                    zero_nxt = Zero;
                end
                if (Halt_req) begin
                    pc_nxt = Prog_ctr;
                end else if (Jump_en) begin
                    pc_nxt = lut_rd;
                end else if (Branch_en && Zero_q) begin
                    pc_nxt = br_target;
                end else begin
                    pc_nxt = Prog_ctr + PC_W'(1);
                end
            end
            S_HALT: begin
                if (Start) begin
                    pc_nxt   = '0;
                    cnt_nxt  = '0;
                    zero_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Prog_ctr  <= '0;
            Cycle_cnt <= '0;
            Zero_q    <= 1'b0;
        end else begin
            Prog_ctr  <= pc_nxt;
            Cycle_cnt <= cnt_nxt;
            Zero_q    <= zero_nxt;
        end
    end

endmodule
